// File: rtl/iicc_tx_sched.sv
// Transmit scheduler for a GT lane: arbitrates sync frames and two user packet
// streams onto a registered 16-bit K-coded word stream, with comma alignment handling.
module iicc_tx_sched #(
  parameter int unsigned SYNC_BYTES = 8
) (
  input  logic        txusrclk,
  input  logic        reset,
  input  logic        rxbyteisaligned,
  input  logic        alignrequest,
  input  logic        sync_valid,
  input  logic [4:0]  sync_action,
  input  logic [63:0] sync_ts,
  output logic        sync_ready,
  input  logic        u0_valid,
  input  logic [15:0] u0_data,
  input  logic        u0_last,
  output logic        u0_ready,
  input  logic        u1_valid,
  input  logic [15:0] u1_data,
  input  logic        u1_last,
  output logic        u1_ready,
  output logic [15:0] txdata,
  output logic [1:0]  txcharisk,
  output logic        abort,
  output logic [1:0]  grant
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned TS_SHIFT = 64 - 8 * SYNC_BYTES;

  localparam logic [15:0] W_ALIGNREQ = 16'h01BC;
  localparam logic [15:0] W_COMMA    = 16'h00BC;
  localparam logic [15:0] W_SOS      = 16'hFCBC;
  localparam logic [15:0] W_SOP0     = 16'h1CBC;
  localparam logic [15:0] W_SOP1     = 16'h3CBC;
  localparam logic [1:0]  K_CTRL     = 2'b01;
  localparam logic [1:0]  K_DATA     = 2'b00;

  typedef enum logic [2:0] {
    ST_ALIGN,
    ST_IDLE,
    ST_SYNC,
    ST_SOP,
    ST_DATA,
    ST_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         action_q, action_d;
  logic [63:0]        ts_q, ts_d;
  logic               sel_q, sel_d;
  logic               last_q, last_d;
  logic               from_data_q, from_data_d;
  logic [1:0]         grant_q, grant_d;
  logic               abort_q, abort_d;
  logic [15:0]        txdata_q, txdata_d;
  logic [1:0]         txk_q, txk_d;

  logic               u_valid, u_last, stall, rdy;
  logic [15:0]        u_data;

  assign u_valid = sel_q ? u1_valid : u0_valid;
  assign u_last  = sel_q ? u1_last  : u0_last;
  assign u_data  = sel_q ? u1_data  : u0_data;
  assign stall   = alignrequest && (state_q == ST_IDLE || state_q == ST_SYNC ||
                                    state_q == ST_SOP  || state_q == ST_DATA);

  // Next-state, next-word and handshake decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    action_d    = action_q;
    ts_d        = ts_q;
    sel_d       = sel_q;
    last_d      = last_q;
    from_data_d = from_data_q;
    grant_d     = grant_q;
    abort_d     = 1'b0;
    txdata_d    = W_COMMA;
    txk_d       = K_CTRL;
    sync_ready  = 1'b0;
    rdy         = 1'b0;

    if (!rxbyteisaligned) begin
      state_d     = ST_ALIGN;
      txdata_d    = W_ALIGNREQ;
      grant_d     = 2'b00;
      abort_d     = (state_q == ST_SYNC || state_q == ST_SOP || state_q == ST_DATA);
      from_data_d = (state_q == ST_DATA) || (state_q == ST_ALIGN && from_data_q);
    end else if (stall) begin
      txdata_d = W_COMMA;
    end else begin
      case (state_q)
        ST_ALIGN: begin
          txdata_d    = W_ALIGNREQ;
          state_d     = from_data_q ? ST_DRAIN : ST_IDLE;
          from_data_d = 1'b0;
        end
        ST_IDLE: begin
          if (sync_valid) begin
            sync_ready = 1'b1;
            action_d   = sync_action;
            ts_d       = sync_ts << TS_SHIFT;
            cnt_d      = '0;
            state_d    = ST_SYNC;
          end else if (u0_valid || u1_valid) begin
            sel_d   = (u0_valid && u1_valid) ? ~last_q : u1_valid;
            state_d = ST_SOP;
          end
        end
        ST_SYNC: begin
          // cnt 0 emits the start-of-sync marker; cnt k emits timestamp byte k-1
          if (cnt_q == '0) begin
            txdata_d = W_SOS;
          end else begin
            txdata_d = {action_q, 3'(cnt_q - CNT_W'(1)), ts_q[63:56]};
            txk_d    = K_DATA;
            ts_d     = ts_q << 8;
          end
          if (cnt_q == CNT_W'(SYNC_BYTES)) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SOP: begin
          txdata_d = sel_q ? W_SOP1 : W_SOP0;
          grant_d  = sel_q ? 2'b10 : 2'b01;
          state_d  = ST_DATA;
        end
        ST_DATA: begin
          rdy = 1'b1;
          if (u_valid) begin
            txdata_d = u_data;
            txk_d    = K_DATA;
            if (u_last) begin
              state_d = ST_IDLE;
              grant_d = 2'b00;
              last_d  = sel_q;
            end
          end
        end
        ST_DRAIN: begin
          rdy = 1'b1;
          if (u_valid && u_last) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d  = ST_ALIGN;
          txdata_d = W_ALIGNREQ;
        end
      endcase
    end
  end

  always_ff @(posedge txusrclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ALIGN;
      cnt_q       <= '0;
      action_q    <= '0;
      ts_q        <= '0;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      from_data_q <= 1'b0;
      grant_q     <= 2'b00;
      abort_q     <= 1'b0;
      txdata_q    <= W_ALIGNREQ;
      txk_q       <= K_CTRL;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      action_q    <= action_d;
      ts_q        <= ts_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      from_data_q <= from_data_d;
      grant_q     <= grant_d;
      abort_q     <= abort_d;
      txdata_q    <= txdata_d;
      txk_q       <= txk_d;
    end
  end

  assign u0_ready  = rdy && !sel_q;
  assign u1_ready  = rdy && sel_q;
  assign txdata    = txdata_q;
  assign txcharisk = txk_q;
  assign abort     = abort_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_iicc_tx_sched.sv
// Directed bench for iicc_tx_sched: expected line words are queued as stimulus
// is applied and checked word-by-word after each clock edge.
module tb_iicc_tx_sched;

  localparam logic [15:0] W_ALIGNREQ = 16'h01BC;
  localparam logic [15:0] W_COMMA    = 16'h00BC;
  localparam logic [15:0] W_SOS      = 16'hFCBC;
  localparam logic [15:0] W_SOP0     = 16'h1CBC;
  localparam logic [15:0] W_SOP1     = 16'h3CBC;
  localparam logic [1:0]  KC         = 2'b01;
  localparam logic [1:0]  KD         = 2'b00;

  logic        txusrclk = 1'b0;
  logic        reset = 1'b0;
  logic        rxbyteisaligned = 1'b0;
  logic        alignrequest = 1'b0;
  logic        sync_valid = 1'b0;
  logic [4:0]  sync_action = '0;
  logic [63:0] sync_ts = '0;
  logic        sync_ready;
  logic        u0_valid = 1'b0, u0_last = 1'b0, u0_ready;
  logic [15:0] u0_data = '0;
  logic        u1_valid = 1'b0, u1_last = 1'b0, u1_ready;
  logic [15:0] u1_data = '0;
  logic [15:0] txdata;
  logic [1:0]  txcharisk;
  logic        abort;
  logic [1:0]  grant;

  iicc_tx_sched #(.SYNC_BYTES(8)) dut (
    .txusrclk(txusrclk), .reset(reset), .rxbyteisaligned(rxbyteisaligned),
    .alignrequest(alignrequest), .sync_valid(sync_valid), .sync_action(sync_action),
    .sync_ts(sync_ts), .sync_ready(sync_ready),
    .u0_valid(u0_valid), .u0_data(u0_data), .u0_last(u0_last), .u0_ready(u0_ready),
    .u1_valid(u1_valid), .u1_data(u1_data), .u1_last(u1_last), .u1_ready(u1_ready),
    .txdata(txdata), .txcharisk(txcharisk), .abort(abort), .grant(grant)
  );

  always #5 txusrclk = ~txusrclk;

  typedef struct {
    string       tag;
    logic [15:0] w;
    logic [1:0]  k;
    logic        ab;
    logic [1:0]  g;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check_bits(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] w, input logic [1:0] k,
                      input logic ab, input logic [1:0] g);
    exp_t e;
    e.tag = tag; e.w = w; e.k = k; e.ab = ab; e.g = g;
    sb.push_back(e);
  endtask

  // One clock: pop the next expected word and compare all line outputs
  task automatic tick();
    exp_t e;
    @(posedge txusrclk);
    #1;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL sb_underflow: observed 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_bits({e.tag, "_txdata"}, txdata, e.w);
      check_bits({e.tag, "_k"}, 16'(txcharisk), 16'(e.k));
      check_bits({e.tag, "_abort"}, 16'(abort), 16'(e.ab));
      check_bits({e.tag, "_grant"}, 16'(grant), 16'(e.g));
    end
  endtask

  function automatic logic [15:0] sync_word(input logic [4:0] a, input logic [63:0] ts, input int i);
    logic [63:0] sh;
    sh = ts >> (8 * (7 - i));
    return {a, 3'(i), sh[7:0]};
  endfunction

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    check_bits("rst_txdata", txdata, W_ALIGNREQ);
    check_bits("rst_k", 16'(txcharisk), 16'(KC));
    check_bits("rst_rdy", 16'({sync_ready, u0_ready, u1_ready}), 16'(3'b000));
    check_bits("rst_abort", 16'(abort), 16'(1'b0));
    check_bits("rst_grant", 16'(grant), 16'(2'b00));
    @(posedge txusrclk);
    #1 reset = 1'b0;

    push("align_hold", W_ALIGNREQ, KC, 1'b0, 2'b00); tick();
    rxbyteisaligned = 1'b1;
    push("align_exit", W_ALIGNREQ, KC, 1'b0, 2'b00); tick();
    push("idle", W_COMMA, KC, 1'b0, 2'b00); tick();

    // Sync frame, action 1, ts 0102..08
    sync_valid = 1'b1; sync_action = 5'h01; sync_ts = 64'h0102030405060708;
    #1;
    check_bits("sync_ready_hs", 16'(sync_ready), 16'(1'b1));
    push("sync_hs", W_COMMA, KC, 1'b0, 2'b00);
    push("sync_sos", W_SOS, KC, 1'b0, 2'b00);
    for (int i = 0; i < 8; i++) push("sync_w", sync_word(5'h01, 64'h0102030405060708, i), KD, 1'b0, 2'b00);
    push("sync_end", W_COMMA, KC, 1'b0, 2'b00);
    tick();
    sync_valid = 1'b0;
    #1;
    check_bits("sync_ready_drop", 16'(sync_ready), 16'(1'b0));
    for (int i = 0; i < 10; i++) tick();
    check_bits("sync_w0_literal", 16'h0801, sync_word(5'h01, 64'h0102030405060708, 0));

    // Alignrequest stall at index 3
    sync_valid = 1'b1; sync_action = 5'h1A; sync_ts = 64'hDEADBEEFCAFEF00D;
    push("stall_hs", W_COMMA, KC, 1'b0, 2'b00);
    push("stall_sos", W_SOS, KC, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) push("stall_w", sync_word(5'h1A, 64'hDEADBEEFCAFEF00D, i), KD, 1'b0, 2'b00);
    push("stall_comma", W_COMMA, KC, 1'b0, 2'b00);
    for (int i = 3; i < 8; i++) push("stall_w", sync_word(5'h1A, 64'hDEADBEEFCAFEF00D, i), KD, 1'b0, 2'b00);
    push("stall_end", W_COMMA, KC, 1'b0, 2'b00);
    tick();
    sync_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    alignrequest = 1'b1;
    tick();
    alignrequest = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Round-robin tie, 2-word packets
    u0_valid = 1'b1; u0_data = 16'hA000; u0_last = 1'b0;
    u1_valid = 1'b1; u1_data = 16'hB000; u1_last = 1'b0;
    push("rr_idle0", W_COMMA, KC, 1'b0, 2'b00); tick();
    push("rr_sop0", W_SOP0, KC, 1'b0, 2'b01); tick();
    #1;
    check_bits("rr_rdy_p0", 16'({u0_ready, u1_ready}), 16'(2'b10));
    push("rr_a0", 16'hA000, KD, 1'b0, 2'b01); tick();
    u0_data = 16'hA001; u0_last = 1'b1;
    push("rr_a1", 16'hA001, KD, 1'b0, 2'b00); tick();
    u0_data = 16'hA100; u0_last = 1'b0;
    push("rr_idle1", W_COMMA, KC, 1'b0, 2'b00); tick();
    push("rr_sop1", W_SOP1, KC, 1'b0, 2'b10); tick();
    push("rr_b0", 16'hB000, KD, 1'b0, 2'b10); tick();
    u1_data = 16'hB001; u1_last = 1'b1;
    push("rr_b1", 16'hB001, KD, 1'b0, 2'b00); tick();
    u1_data = 16'hB100; u1_last = 1'b0;
    push("rr_idle2", W_COMMA, KC, 1'b0, 2'b00); tick();
    u1_valid = 1'b0;
    push("rr_sop0b", W_SOP0, KC, 1'b0, 2'b01); tick();
    push("rr_c0", 16'hA100, KD, 1'b0, 2'b01); tick();
    u0_data = 16'hA101; u0_last = 1'b1;
    push("rr_c1", 16'hA101, KD, 1'b0, 2'b00); tick();
    u0_valid = 1'b0; u0_last = 1'b0;
    push("rr_done", W_COMMA, KC, 1'b0, 2'b00); tick();

    // Abort after 2 of 5 words on u1, then drain
    u1_valid = 1'b1; u1_data = 16'hC000; u1_last = 1'b0;
    push("ab_idle", W_COMMA, KC, 1'b0, 2'b00); tick();
    push("ab_sop1", W_SOP1, KC, 1'b0, 2'b10); tick();
    push("ab_w0", 16'hC000, KD, 1'b0, 2'b10); tick();
    u1_data = 16'hC001;
    push("ab_w1", 16'hC001, KD, 1'b0, 2'b10); tick();
    u1_data = 16'hC002; rxbyteisaligned = 1'b0;
    #1;
    check_bits("ab_rdy_lost", 16'(u1_ready), 16'(1'b0));
    push("ab_pulse", W_ALIGNREQ, KC, 1'b1, 2'b00); tick();
    push("ab_hold", W_ALIGNREQ, KC, 1'b0, 2'b00); tick();
    rxbyteisaligned = 1'b1;
    push("ab_realign", W_ALIGNREQ, KC, 1'b0, 2'b00); tick();
    #1;
    check_bits("drain_rdy", 16'({u0_ready, u1_ready}), 16'(2'b01));
    push("drain_w2", W_COMMA, KC, 1'b0, 2'b00); tick();
    u1_data = 16'hC003;
    push("drain_w3", W_COMMA, KC, 1'b0, 2'b00); tick();
    u1_data = 16'hC004; u1_last = 1'b1;
    push("drain_w4", W_COMMA, KC, 1'b0, 2'b00); tick();
    #1;
    check_bits("drain_rdy_done", 16'(u1_ready), 16'(1'b0));
    u1_valid = 1'b0; u1_last = 1'b0;
    push("drain_idle", W_COMMA, KC, 1'b0, 2'b00); tick();

    // Sync and u0 together: sync wins, then SOP0
    sync_valid = 1'b1; sync_action = 5'h03; sync_ts = 64'h1122334455667788;
    u0_valid = 1'b1; u0_data = 16'hE000; u0_last = 1'b1;
    #1;
    check_bits("sim_rdy", 16'({sync_ready, u0_ready}), 16'(2'b10));
    push("sim_hs", W_COMMA, KC, 1'b0, 2'b00);
    push("sim_sos", W_SOS, KC, 1'b0, 2'b00);
    for (int i = 0; i < 8; i++) push("sim_w", sync_word(5'h03, 64'h1122334455667788, i), KD, 1'b0, 2'b00);
    push("sim_idle", W_COMMA, KC, 1'b0, 2'b00);
    push("sim_sop0", W_SOP0, KC, 1'b0, 2'b01);
    push("sim_e0", 16'hE000, KD, 1'b0, 2'b00);
    tick();
    sync_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    u0_valid = 1'b0; u0_last = 1'b0;
    push("sim_done", W_COMMA, KC, 1'b0, 2'b00); tick();

    // Async reset mid-packet
    u1_valid = 1'b1; u1_data = 16'hF000; u1_last = 1'b0;
    push("rs_idle", W_COMMA, KC, 1'b0, 2'b00); tick();
    push("rs_sop1", W_SOP1, KC, 1'b0, 2'b10); tick();
    push("rs_f0", 16'hF000, KD, 1'b0, 2'b10); tick();
    #3 reset = 1'b1;
    #1;
    check_bits("rs_txdata", txdata, W_ALIGNREQ);
    check_bits("rs_k", 16'(txcharisk), 16'(KC));
    check_bits("rs_rdy", 16'({sync_ready, u0_ready, u1_ready}), 16'(3'b000));
    check_bits("rs_abort", 16'(abort), 16'(1'b0));
    check_bits("rs_grant", 16'(grant), 16'(2'b00));
    push("rs_held", W_ALIGNREQ, KC, 1'b0, 2'b00); tick();
    reset = 1'b0;
    u0_valid = 1'b1; u0_data = 16'h5000;
    push("rs_exit", W_ALIGNREQ, KC, 1'b0, 2'b00); tick();
    push("rs_tie", W_COMMA, KC, 1'b0, 2'b00); tick();
    push("rs_sop0", W_SOP0, KC, 1'b0, 2'b01); tick();
    u0_valid = 1'b0; u1_valid = 1'b0;

    check_bits("sb_drained", 16'(sb.size()), 16'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iicc_tx_sched.md
IICC_TX_SCHED -- requirements
Module: iicc_tx_sched

Interface
REQ-001 The block SHALL have parameter SYNC_BYTES, default 8, meaning the number of timestamp bytes per sync frame (supported range 1..8).
REQ-002 The block SHALL have port txusrclk, input, 1 bit: the GT transmit user clock, the only clock.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port rxbyteisaligned, input, 1 bit: receiver comma alignment, already synchronous to txusrclk.
REQ-005 The block SHALL have port alignrequest, input, 1 bit: the peer requested a comma this cycle.
REQ-006 The block SHALL have ports sync_valid (input, 1), sync_action (input, 5), sync_ts (input, 64) and sync_ready (output, 1): the sync-frame request.
REQ-007 The block SHALL have ports uN_valid (input, 1), uN_data (input, 16), uN_last (input, 1) and uN_ready (output, 1), for N=0,1: the user packet requesters.
REQ-008 The block SHALL have ports txdata (output, 16) and txcharisk (output, 2): GT transmit word and K flags.
REQ-009 The block SHALL have port abort, output, 1 bit: one-cycle pulse when an in-flight frame or packet is cut.
REQ-010 The block SHALL have port grant, output, 2 bits: one-hot active user port, 0 otherwise.

Function
REQ-011 Word encodings SHALL be:
  - ALIGNREQ 16'h01BC/K=01
  - COMMA 16'h00BC/K=01
  - SOS 16'hFCBC/K=01
  - SOP0 16'h1CBC/K=01
  - SOP1 16'h3CBC/K=01
  - sync word {action[4:0], index[2:0], byte[7:0]}/K=00
  - user word uN_data/K=00
REQ-012 txdata and txcharisk SHALL be registered; a word decided at edge k SHALL be visible after edge k; a user word SHALL be transmitted on the edge where uN_valid&uN_ready=1.
REQ-013 The state machine SHALL have states ALIGN, IDLE, SYNC, SOP, DATA and DRAIN.
REQ-014 ALIGN: output ALIGNREQ and all readies 0; when rxbyteisaligned=1, the next state SHALL be DRAIN if entered from DATA, otherwise IDLE.
REQ-015 rxbyteisaligned=0 in any state SHALL force ALIGN on the next edge, with precedence over all other events.
  - If the state was SYNC, SOP or DATA, abort SHALL pulse for one cycle.
  - The cut frame or packet SHALL NOT be resumed.
REQ-016 alignrequest=1 in IDLE, SYNC, SOP or DATA SHALL cause:
  - output COMMA for that cycle;
  - all readies 0;
  - state, byte index and word position held (a stall, not an abort).
REQ-017 IDLE SHALL output COMMA and choose in this priority order:
  - sync_valid → SYNC;
  - otherwise one uN_valid → SOP for that port;
  - both uN_valid → round-robin, granting the port not served last; after reset, port 0 wins the first tie.
REQ-018 Entry into SYNC SHALL behave as follows:
  - sync_ready pulses for 1 cycle;
  - sync_action and sync_ts are captured;
  - SOS is output, then SYNC_BYTES sync words with index 0..SYNC_BYTES-1, ts bytes MSB first;
  - then IDLE.
REQ-019 SOP SHALL output SOP0 or SOP1 for 1 cycle, set grant, then go to DATA.
REQ-020 DATA SHALL behave as follows:
  - uN_ready=1 for the granted port only;
  - valid=0 outputs COMMA as fill (no state change);
  - a transfer with uN_last=1 returns to IDLE, clears grant and records the port as last served.
REQ-021 DRAIN SHALL behave as follows:
  - output COMMA;
  - uN_ready=1 for the aborted port, words are discarded;
  - on transfer with uN_last=1 → IDLE;
  - alignment loss → ALIGN with no further abort pulse.
REQ-022 Packets SHALL have no length limit, and sync frames SHALL never preempt a packet; sync_valid arriving in DATA SHALL wait until IDLE.
REQ-023 sync_valid and uN_valid asserted in the same IDLE cycle SHALL grant sync, leaving the round-robin pointer unchanged.

Reset
REQ-024 While reset=1, the block SHALL hold:
  - state=ALIGN, txdata=16'h01BC, txcharisk=2'b01;
  - sync_ready=0, u0_ready=0, u1_ready=0, abort=0, grant=0;
  - last-served=1.
REQ-025 After reset deasserts, the block SHALL emit ALIGNREQ until rxbyteisaligned=1; reset mid-frame or mid-packet SHALL NOT pulse abort.

Verification
REQ-026 The bench SHALL cover the sync frame: aligned, sync_valid=1, action=5'h1, ts=64'h0102030405060708 → 16'hFCBC/K=01 then 16'h0801, 0902, …, 0F08 (all K=00), then COMMA.
REQ-027 The bench SHALL cover the round-robin tie: u0 and u1 each send a 2-word packet, both valid continuously → SOP0, u0 words, SOP1, u1 words, then SOP0 again.
REQ-028 The bench SHALL cover the alignrequest stall: a pulse mid-sync at index 3 → one COMMA/K=01 inserted, index 3 resent next, 8 data words total, abort=0.
REQ-029 The bench SHALL cover abort and drain: rxbyteisaligned=0 after 2 words of a 5-word u1 packet → ALIGNREQ, abort pulse, then on realign 3 words consumed as COMMA and back to IDLE.
REQ-030 The bench SHALL cover simultaneous requests: sync_valid with u0_valid in IDLE → sync frame first, then SOP0.
REQ-031 The bench SHALL cover async reset mid-packet: assert reset between edges → outputs become ALIGNREQ immediately, all readies 0, abort stays 0.
